shift_deserializer: RTL
=======================

Name: shift_deserializer

Overview:
- Receive-side counterpart of the team's parallel shift register. It assembles a serial bit stream into a parallel word of programmable length, either MSB-first or LSB-first.
- The completed word is right-justified, zero-extended, and presented on a valid/ready handshake.
- It sits between a serial link or bit source and the datapath that consumes the bidirectionally shifted words.

Parameters:
- WIDTH, 8, maximum word width in bits; the output port width.
- CNT_W, 3, width of the length field; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial data bit.
- bit_valid  input  1  serial_in is valid this cycle.
- frame_start  input  1  qualifies bit_valid; marks the first bit of a word.
- right_not_left  input  1  1 = LSB-first (right shift in); 0 = MSB-first (left shift in). Sampled on the frame_start bit.
- N  input  CNT_W  word length minus 1 (0..WIDTH-1). Sampled on the frame_start bit.
- word_out  output  WIDTH  assembled word.
- word_valid  output  1  word_out holds a complete word.
- word_ready  input  1  consumer accepts word_out.
- busy  output  1  a frame is in progress (SHIFT state).
- overrun  output  1  sticky flag: a bit arrived while a word was pending.

Behaviour:
- Reset (async, active-high): state=IDLE, shift register=0, bit count=0, word_out=0, word_valid=0, busy=0, overrun=0.
- States: IDLE, SHIFT, HOLD. Encoding lives in the package.
- IDLE:
  - bit_valid without frame_start: bit ignored.
  - bit_valid && frame_start: latch dir=right_not_left and len=N+1, shift in the first bit, count=1.
  - Next state is HOLD if len==1, else SHIFT.
- SHIFT:
  - Each bit_valid shifts in one bit and increments count.
  - When count reaches len, go to HOLD. word_valid rises on the clock edge after the last bit (1-cycle latency).
  - Cycles without bit_valid: hold state, no change.
- Shift rules:
  - MSB-first: sr <= {sr[WIDTH-2:0], bit}.
  - LSB-first: sr <= {bit, sr[WIDTH-1:1]}.
- Alignment on entry to HOLD:
  - MSB-first: word_out = sr (already right-justified).
  - LSB-first: word_out = sr >> (WIDTH-len).
  - In both modes, bits above len-1 are 0.
  - Result: in LSB-first mode the k-th received bit lands at word_out[k]; in MSB-first mode it lands at word_out[len-1-k].
- HOLD:
  - word_valid=1; word_out is stable until the handshake.
  - word_valid && word_ready: handshake completes, word_valid drops next cycle, return to IDLE.
- Back-to-back: handshake plus bit_valid && frame_start in the same cycle starts the new frame (goes to SHIFT, or to HOLD with the new word if len==1). No bubble.
- Overrun: bit_valid in HOLD without a handshake in the same cycle drops the bit and sets overrun. overrun is cleared only by reset.
- Resync: frame_start with bit_valid during SHIFT aborts the partial word (discarded, no word_valid). A new frame starts with that bit and freshly sampled N/dir.
- Mid-frame changes: changes on N or right_not_left during SHIFT are ignored; the latched values are used.
- busy=1 exactly while in SHIFT.
- Reset asserted mid-frame or in HOLD: all state is cleared immediately and the pending word is lost.

Decomposition:
- Package shift_deser_pkg holds:
  - the state enum (IDLE/SHIFT/HOLD);
  - the WIDTH default and CNT_W;
  - the direction constants DIR_LEFT=0 and DIR_RIGHT=1.
- One combinational sub-module, shift_align: a barrel right-shift of WIDTH bits by (WIDTH-len) with zero fill, instantiated on the HOLD-entry path.
- The FSM, counter and shift register stay in the top module.

Test Plan:
- MSB-first, N=7, bits 1,0,1,1,0,0,1,0 on consecutive cycles, word_ready=1 -> word_valid one cycle after the 8th bit, word_out=0xB2, back to IDLE the next cycle.
- LSB-first, N=7, the same bits -> word_out=0x4D.
- N=3: LSB-first bits 1,1,0,1 -> 0x0B. MSB-first bits 1,1,0,1 -> 0x0D. Bits [7:4]=0 in both cases.
- N=0, MSB-first single bit 1 -> HOLD immediately, word_out=0x01. Hold word_ready=0 and send another bit -> overrun=1, word_out stays 0x01.
- Back-to-back: handshake on the same cycle as frame_start of the next frame -> second word (0xA5, MSB-first) produced with no lost bit. Gaps of bit_valid=0 mid-frame -> same result.
- Resync after 3 bits with a new frame_start -> first partial word never flagged, second word correct. Reset asserted in SHIFT and again in HOLD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
// Holds the FSM state encoding, default geometry and shift-direction codes.
package shift_deser_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_align.sv
// Zero-filling logarithmic barrel right-shifter; right-justifies LSB-first
// words that were shifted in from the top of the register.
module shift_align
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic [WIDTH-1:0] data,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] stage [CNT_W+1];

  assign stage[0] = data;

  for (genvar i = 0; i < CNT_W; i++) begin : g_stage
    assign stage[i+1] = shamt[i] ? (stage[i] >> (2 ** i)) : stage[i];
  end

  assign result = stage[CNT_W];

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel word assembler with programmable length and bit order;
// completed words are right-justified and offered on a valid/ready handshake.
module shift_deserializer
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             right_not_left,
  input  logic [CNT_W-1:0] N,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int LEN_W = CNT_W + 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [WIDTH-1:0] aligned, word_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [LEN_W-1:0] len, len_n;
  logic [CNT_W-1:0] shamt;
  logic             dir, dir_n;
  logic             start, begin_frame, load_word, ovr_set;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic b,
                                                input logic d);
    return (d == DIR_RIGHT) ? {b, cur[WIDTH-1:1]} : {cur[WIDTH-2:0], b};
  endfunction

  assign start = bit_valid & frame_start;

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    cnt_n       = cnt;
    len_n       = len;
    dir_n       = dir;
    begin_frame = 1'b0;
    load_word   = 1'b0;
    ovr_set     = 1'b0;

    unique case (state)
      IDLE: begin
        begin_frame = start;
      end
      SHIFT: begin
        if (start) begin
          begin_frame = 1'b1;
        end else if (bit_valid) begin
          sr_n  = shift_in(sr, serial_in, dir);
          cnt_n = cnt + LEN_W'(1);
          if (cnt_n == len) begin
            state_n   = HOLD;
            load_word = 1'b1;
          end
        end
      end
      HOLD: begin
        if (word_ready) begin
          state_n     = IDLE;
          begin_frame = start;
        end else if (bit_valid) begin
          ovr_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A frame start (from any state that accepts one) discards whatever was
    // partially assembled and restarts from an empty register.
    if (begin_frame) begin
      dir_n = right_not_left;
      len_n = {1'b0, N} + LEN_W'(1);
      sr_n  = shift_in('0, serial_in, right_not_left);
      cnt_n = LEN_W'(1);
      if (len_n == LEN_W'(1)) begin
        state_n   = HOLD;
        load_word = 1'b1;
      end else begin
        state_n = SHIFT;
      end
    end
  end

  assign shamt  = CNT_W'(LEN_W'(WIDTH) - len_n);
  assign word_n = (dir_n == DIR_RIGHT) ? aligned : sr_n;

  shift_align #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_align (
    .data  (sr_n),
    .shamt (shamt),
    .result(aligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      len      <= '0;
      dir      <= DIR_LEFT;
      word_out <= '0;
      overrun  <= 1'b0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
      len   <= len_n;
      dir   <= dir_n;
      if (load_word) word_out <= word_n;
      if (ovr_set)   overrun  <= 1'b1;
    end
  end

  assign word_valid = (state == HOLD);
  assign busy       = (state == SHIFT);

endmodule
